// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core pipeline control.
//   hazard_state_t : memory-wait sequencer states (RUN, MEM_WAIT, ERROR)
//   FWD_*          : execute-stage ALU operand source selects
package riscv_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazard_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_forward.sv
// Execute-stage forwarding compare (purely combinational).
// Ports:
//   rs1_e, rs2_e               : source registers in execute
//   rd_m, rd_w                 : destinations in memory / writeback
//   reg_write_m, reg_write_w   : write enables in memory / writeback
//   forward_a_e, forward_b_e   : operand selects (FWD_RF / FWD_WB / FWD_MEM)
module hazard_forward
  import riscv_pkg::*;
(
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e
);

  // The memory stage holds the younger result, so it wins over writeback.
  // x0 is never forwarded since it always reads as zero.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  always_comb begin
    forward_a_e = fwd_sel(rs1_e);
    forward_b_e = fwd_sel(rs2_e);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the five-stage core.
// Drives stall/flush enables of the pipeline registers, the execute-stage
// forwarding selects, sequences multi-cycle data-memory waits with a
// watchdog, and keeps saturating stall/flush event counters.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   rs1_d, rs2_d                     : decode-stage sources
//   rs1_e, rs2_e, rd_e, load_e       : execute-stage operands / load flag
//   pc_src_e                         : taken branch/jump in execute
//   rd_m, rd_w, reg_write_m/_w       : later-stage writers
//   dmem_req_m, dmem_ready_m         : data-memory handshake
//   stall_f/d/e/m, flush_d/e/w       : pipeline register controls
//   forward_a_e, forward_b_e         : ALU operand selects
//   mem_timeout                      : sticky watchdog error
//   stall_count, flush_count         : saturating event counters
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | normal flow; a req without ready stalls and enters MEM_WAIT
// MEM_WAIT | memory access outstanding; pipeline frozen, watchdog counts
// ERROR    | watchdog expired; pipeline frozen until reset
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic             load_e,
  input  logic             pc_src_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             dmem_req_m,
  input  logic             dmem_ready_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  hazard_state_t    state_q;
  logic [7:0]       wait_cnt_q;
  logic             mem_timeout_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             ms;
  logic             branch_taken;

  hazard_forward u_forward (
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e)
  );

  always_comb begin
    lu = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    // The first cycle of a wait is still RUN, so the stall must come
    // straight from the handshake rather than from the state alone.
    ms = (state_q == MEM_WAIT) || (state_q == ERROR) ||
         ((state_q == RUN) && dmem_req_m && !dmem_ready_m);

    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_w      = 1'b0;
    branch_taken = 1'b0;

    if (ms) begin
      // A branch in execute stays frozen in D/E and is honoured later.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      // The flush already removes the dependent instruction in decode.
      flush_d      = 1'b1;
      flush_e      = 1'b1;
      branch_taken = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (branch_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (dmem_req_m && !dmem_ready_m) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready_m) begin
            state_q <= RUN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q       <= ERROR;
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ERROR: begin
          state_q <= ERROR;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic load_e, pc_src_e, reg_write_m, reg_write_w, dmem_req_m, dmem_ready_m;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0] forward_a_e, forward_b_e;
  logic mem_timeout;
  logic [CW-1:0] stall_count, flush_count;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .load_e(load_e), .pc_src_e(pc_src_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the memory sequencer is tracked as "stalled cycles
  // spent on the current access" plus a sticky error flag.
  bit m_err;
  int m_n;
  int m_sc, m_fc;

  function automatic int fwd(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 1;
    return 0;
  endfunction

  task automatic clr();
    reset = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; pc_src_e = 0; reg_write_m = 0; reg_write_w = 0;
    dmem_req_m = 0; dmem_ready_m = 0;
  endtask

  // Inputs are already applied (#1 after an edge). Check, then clock once.
  task automatic step();
    bit ms, lu, br, lus;
    logic [6:0] ctl;
    #3;
    ms  = m_err || (m_n > 0) || (dmem_req_m && !dmem_ready_m);
    lu  = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    br  = !ms && pc_src_e;
    lus = !ms && !pc_src_e && lu;
    ctl = {ms || lus, ms || lus, ms, ms, br, br || lus, ms};
    check("ctl", {25'd0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}, {25'd0, ctl});
    check("fwd_a", {30'd0, forward_a_e}, fwd(rs1_e));
    check("fwd_b", {30'd0, forward_b_e}, fwd(rs2_e));
    check("timeout", {31'd0, mem_timeout}, {31'd0, m_err});
    check("stall_cnt", {28'd0, stall_count}, m_sc);
    check("flush_cnt", {28'd0, flush_count}, m_fc);
    @(posedge clk);
    if (reset) begin
      m_err = 0; m_n = 0; m_sc = 0; m_fc = 0;
    end else begin
      if ((ms || lus) && m_sc < CMAX) m_sc++;
      if (br && m_fc < CMAX) m_fc++;
      if (!m_err) begin
        if (m_n > 0 && dmem_ready_m) m_n = 0;
        else if (ms) begin
          m_n++;
          if (m_n == TO) m_err = 1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clr(); reset = 1; step(); reset = 0;
  endtask

  initial begin
    m_err = 0; m_n = 0; m_sc = 0; m_fc = 0;
    clr();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    step();

    // forwarding priority
    rs1_e = 5; rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1; #1;
    check("fwd_mem", {30'd0, forward_a_e}, 32'd2);
    reg_write_m = 0; #1;
    check("fwd_wb", {30'd0, forward_a_e}, 32'd1);
    rd_w = 0; #1;
    check("fwd_rf", {30'd0, forward_a_e}, 32'd0);
    step();

    // load-use
    do_reset();
    load_e = 1; rd_e = 3; rs2_d = 3; step();
    clr(); step();
    check("lu_cnt", {28'd0, stall_count}, 32'd1);
    load_e = 1; rd_e = 0; rs2_d = 0; #1;
    check("lu_x0", {31'd0, stall_f}, 32'd0);
    step();

    // branch overrides load-use
    do_reset();
    load_e = 1; rd_e = 3; rs1_d = 3; pc_src_e = 1; #1;
    check("br_stall_f", {31'd0, stall_f}, 32'd0);
    step(); clr(); step();
    check("br_cnt", {28'd0, flush_count}, 32'd1);

    // three-cycle memory wait: RUN + two MEM_WAIT, ready on the last
    do_reset();
    dmem_req_m = 1; dmem_ready_m = 0; step(); step();
    dmem_ready_m = 1; step();
    clr(); step();
    check("mw_cnt", {28'd0, stall_count}, 32'd3);

    // single-cycle access produces no stall
    dmem_req_m = 1; dmem_ready_m = 1; #1;
    check("mw_fast", {31'd0, stall_f}, 32'd0);
    step(); clr();

    // watchdog
    do_reset();
    dmem_req_m = 1; dmem_ready_m = 0;
    repeat (TO) step();
    check("to_flag", {31'd0, mem_timeout}, 32'd1);
    dmem_req_m = 0; dmem_ready_m = 1; step(); step();
    check("to_stall", {31'd0, stall_m}, 32'd1);
    do_reset();
    check("to_clear", {31'd0, mem_timeout}, 32'd0);
    step();

    // saturation
    load_e = 1; rd_e = 7; rs1_d = 7;
    repeat (20) step();
    check("sat", {28'd0, stall_count}, CMAX);
    clr();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 39) == 0);
      rs1_d        = 5'($urandom_range(0, 3));
      rs2_d        = 5'($urandom_range(0, 3));
      rs1_e        = 5'($urandom_range(0, 3));
      rs2_e        = 5'($urandom_range(0, 3));
      rd_e         = 5'($urandom_range(0, 3));
      rd_m         = 5'($urandom_range(0, 3));
      rd_w         = 5'($urandom_range(0, 3));
      load_e       = 1'($urandom_range(0, 1));
      pc_src_e     = ($urandom_range(0, 3) == 0);
      reg_write_m  = 1'($urandom_range(0, 1));
      reg_write_w  = 1'($urandom_range(0, 1));
      dmem_req_m   = ($urandom_range(0, 3) == 0);
      dmem_ready_m = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
